// File: rtl/spi_master_txn_pkg.sv
// Shared SPI framing definitions: FSM states and command-byte layout,
// common to this master and the team's SPI slave peripheral.
package spi_pkg;
   localparam int CMD_RW_BIT = 7;
   localparam int CMD_ADDR_W = 7;
   localparam int BYTE_W     = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      HIGH,
      LOW,
      HOLD,
      GAP
   } state_t;
endpackage

// File: rtl/spi_master_txn_timer.sv
// Half-period timer: counts DIV cycles after each restart and then holds expire
// high until it is restarted again.
module spi_half_period_timer #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_restart,
   output logic o_expire
);
   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   assign o_expire = (r_cnt == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          r_cnt <= '0;
      else if (i_restart)    r_cnt <= '0;
      else if (!o_expire)    r_cnt <= r_cnt + 1'b1;
   end
endmodule

// File: rtl/spi_master_txn.sv
// SPI Mode 0 framed-transaction master: a {rw,addr} command byte followed by
// len data bytes, MSB first, with per-byte txReady/rxValid handshakes.
module spi_master_txn
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int LEN_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  rw,
   input  logic [CMD_ADDR_W-1:0] addr,
   input  logic [LEN_W-1:0]      len,
   input  logic [BYTE_W-1:0]     txData,
   output logic                  txReady,
   output logic [BYTE_W-1:0]     rxData,
   output logic                  rxValid,
   output logic                  busy,
   output logic                  done,
   output logic                  sck,
   output logic                  cs,
   output logic                  mosi,
   input  logic                  miso
);
   state_t              r_state, w_state_n;
   logic                r_busy, r_cs, r_sck, r_done, r_txrdy, r_rxv;
   logic                r_rw, r_first;
   logic [2:0]          r_bit;
   logic [LEN_W-1:0]    r_left;
   logic [BYTE_W-1:0]   r_shift, r_rx, r_rxd;

   logic                w_exp, w_restart;
   logic                w_accept, w_rise, w_fall, w_cs_off, w_fin;
   logic                w_more;
   logic [LEN_W-1:0]    w_left_dec;

   spi_half_period_timer #(.DIV(CLK_DIV)) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_restart (w_restart),
      .o_expire  (w_exp)
   );

   // Command byte never consumes a count; data bytes decrement, saturating at 0.
   assign w_left_dec = (r_left != '0) ? r_left - LEN_W'(1) : r_left;
   assign w_more     = r_first ? (r_left != '0) : (w_left_dec != '0);
   assign w_restart  = (w_state_n != r_state);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_n;
   end

   always_comb begin
      w_state_n = r_state;
      w_accept  = 1'b0;
      w_rise    = 1'b0;
      w_fall    = 1'b0;
      w_cs_off  = 1'b0;
      w_fin     = 1'b0;
      case (r_state)
         IDLE:  if (start && !r_busy) begin w_accept = 1'b1; w_state_n = SETUP; end
         SETUP: if (w_exp) begin w_rise = 1'b1; w_state_n = HIGH; end
         HIGH:  if (w_exp) begin
                   w_fall    = 1'b1;
                   w_state_n = (r_bit != 3'd7 || w_more) ? LOW : HOLD;
                end
         LOW:   if (w_exp) begin w_rise = 1'b1; w_state_n = HIGH; end
         HOLD:  if (w_exp) begin w_cs_off = 1'b1; w_state_n = GAP; end
         GAP:   if (w_exp) begin w_fin = 1'b1; w_state_n = IDLE; end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_busy  <= 1'b0;
         r_cs    <= 1'b1;
         r_sck   <= 1'b0;
         r_done  <= 1'b0;
         r_txrdy <= 1'b0;
         r_rxv   <= 1'b0;
         r_rw    <= 1'b0;
         r_first <= 1'b0;
         r_bit   <= '0;
         r_left  <= '0;
         r_shift <= '0;
         r_rx    <= '0;
         r_rxd   <= '0;
      end else begin
         r_done  <= 1'b0;
         r_txrdy <= 1'b0;
         r_rxv   <= 1'b0;
         if (w_accept) begin
            r_rw    <= rw;
            r_left  <= len;
            r_shift <= {rw, addr};
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_bit   <= '0;
            r_first <= 1'b1;
         end
         if (w_rise) begin
            r_sck <= 1'b1;
            r_rx  <= {r_rx[BYTE_W-2:0], miso};
         end
         if (w_fall) begin
            r_sck <= 1'b0;
            r_bit <= r_bit + 3'd1;
            if (r_bit != 3'd7) begin
               r_shift <= {r_shift[BYTE_W-2:0], 1'b0};
            end else begin
               if (!r_first && !r_rw) begin
                  r_rxd <= r_rx;
                  r_rxv <= 1'b1;
               end
               if (!r_first) r_left <= w_left_dec;
               r_first <= 1'b0;
               // Reads shift out zeros while the slave drives miso.
               if (w_more) begin
                  if (r_rw) begin
                     r_shift <= txData;
                     r_txrdy <= 1'b1;
                  end else begin
                     r_shift <= '0;
                  end
               end
            end
         end
         if (w_cs_off) r_cs <= 1'b1;
         if (w_fin) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
         end
      end
   end

   assign txReady = r_txrdy;
   assign rxData  = r_rxd;
   assign rxValid = r_rxv;
   assign busy    = r_busy;
   assign done    = r_done;
   assign sck     = r_sck;
   assign cs      = r_cs;
   assign mosi    = r_shift[BYTE_W-1];
endmodule

// File: tb/tb_spi_master_txn.sv
// Directed bench for spi_master_txn: CLK_DIV=2 instance for framing/handshake
// checks and a CLK_DIV=1 instance for sck phase timing.
module tb_spi_master_txn;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, start, rw, miso, clr;
   logic [6:0] addr;
   logic [7:0] len, txData, rxData, tx0, tx1;
   logic       txReady, rxValid, busy, done, sck, cs, mosi;
   logic [15:0] pat;

   logic       start1, rw1, txReady1, rxValid1, busy1, done1, sck1, cs1, mosi1;
   logic [6:0] addr1;
   logic [7:0] len1, txData1, rxData1;

   int checks = 0;
   int errors = 0;

   int rise_cnt, tr_cnt, rv_cnt, dn_cnt, csl_cnt, busy_cnt, hi_run, last_hi;
   logic [31:0] cap;
   logic prev_sck;
   int rise1, bad1, chg1;
   logic [31:0] cap1;
   logic ps1, pm1, pcs1;

   assign txData = (tr_cnt == 0) ? tx0 : tx1;
   assign miso   = (rise_cnt < 16) ? pat[4'(15 - rise_cnt)] : 1'b0;

   spi_master_txn #(.CLK_DIV(2), .LEN_W(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr), .len(len),
      .txData(txData), .txReady(txReady), .rxData(rxData), .rxValid(rxValid),
      .busy(busy), .done(done), .sck(sck), .cs(cs), .mosi(mosi), .miso(miso)
   );

   spi_master_txn #(.CLK_DIV(1), .LEN_W(8)) dut1 (
      .clk(clk), .reset_n(reset_n), .start(start1), .rw(rw1), .addr(addr1), .len(len1),
      .txData(txData1), .txReady(txReady1), .rxData(rxData1), .rxValid(rxValid1),
      .busy(busy1), .done(done1), .sck(sck1), .cs(cs1), .mosi(mosi1), .miso(1'b0)
   );

   // Observe both DUTs 1 time unit after each active edge.
   always @(posedge clk) begin
      #1;
      if (clr) begin
         rise_cnt = 0; tr_cnt = 0; rv_cnt = 0; dn_cnt = 0; csl_cnt = 0; busy_cnt = 0;
         cap = '0; rise1 = 0; bad1 = 0; chg1 = 0; cap1 = '0;
      end else begin
         if (sck && !prev_sck) begin rise_cnt++; cap = {cap[30:0], mosi}; end
         if (txReady) tr_cnt++;
         if (rxValid) rv_cnt++;
         if (done)    dn_cnt++;
         if (!cs)     csl_cnt++;
         if (busy)    busy_cnt++;
         if (sck1 && !ps1) begin
            rise1++;
            cap1 = {cap1[30:0], mosi1};
            if (mosi1 !== pm1) chg1++;
         end
         if (sck1 && ps1) bad1++;
         if (!sck1 && !ps1 && !cs1 && !pcs1) bad1++;
      end
      if (cs) hi_run++;
      else begin
         if (hi_run != 0) last_hi = hi_run;
         hi_run = 0;
      end
      prev_sck = sck;
      ps1 = sck1; pm1 = mosi1; pcs1 = cs1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic r, input logic [6:0] a, input logic [7:0] l);
      rw = r; addr = a; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clear();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Waits for done; optionally pulses a stray start at cycle inj.
   task automatic wait_done(input int bound, input int inj);
      int n = 0;
      while (done !== 1'b1 && n < bound) begin
         if (n == inj) begin start = 1'b1; rw = 1'b0; addr = 7'h55; len = 8'd7; end
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      chk("done_seen", done, 1);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; rw = 1'b0; addr = '0; len = '0; clr = 1'b1;
      tx0 = '0; tx1 = '0; pat = '0; hi_run = 0; last_hi = 0; prev_sck = 1'b0;
      start1 = 1'b0; rw1 = 1'b0; addr1 = '0; len1 = '0; txData1 = '0;
      ps1 = 1'b0; pm1 = 1'b0; pcs1 = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cs", cs, 1);
      chk("rst_sck", sck, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_txready", txReady, 0);
      chk("rst_rxvalid", rxValid, 0);
      chk("rst_rxdata", rxData, 8'h00);
      reset_n = 1'b1;
      @(negedge clk);
      clr = 1'b0;

      // Write frame with a stray start mid-frame.
      tx0 = 8'hA5; tx1 = 8'h3C;
      clear();
      go(1'b1, 7'h05, 8'd2);
      wait_done(400, 20);
      chk("wr_rises", rise_cnt, 24);
      chk("wr_mosi", cap[23:0], 24'h85A53C);
      chk("wr_txready", tr_cnt, 2);
      chk("wr_rxvalid", rv_cnt, 0);
      chk("wr_done", dn_cnt, 1);
      chk("wr_cs_low", csl_cnt, 98);
      chk("wr_busy_cycles", busy_cnt, 100);
      chk("wr_busy_end", busy, 0);

      // Read frame started on the cycle after done.
      clr = 1'b1;
      pat = {8'h00, 8'h5A};
      @(negedge clk);
      clr = 1'b0;
      go(1'b0, 7'h10, 8'd1);
      chk("b2b_accept", busy, 1);
      wait_done(300, -1);
      chk("rd_rises", rise_cnt, 16);
      chk("rd_mosi", cap[15:0], 16'h1000);
      chk("rd_rxvalid", rv_cnt, 1);
      chk("rd_rxdata", rxData, 8'h5A);
      chk("rd_txready", tr_cnt, 0);
      chk("rd_done", dn_cnt, 1);
      chk("b2b_gap_ok", (last_hi >= 2), 1);

      // Command byte only.
      pat = '0;
      clear();
      go(1'b1, 7'h7F, 8'd0);
      wait_done(200, -1);
      chk("cmd_rises", rise_cnt, 8);
      chk("cmd_mosi", cap[7:0], 8'hFF);
      chk("cmd_cs_low", csl_cnt, 34);
      chk("cmd_busy_cycles", busy_cnt, 36);
      chk("cmd_txready", tr_cnt, 0);
      chk("cmd_rxvalid", rv_cnt, 0);
      chk("cmd_done", dn_cnt, 1);

      // Reset after the 11th sck pulse.
      clear();
      go(1'b1, 7'h05, 8'd2);
      for (int n = 0; n < 400 && rise_cnt < 11; n++) @(negedge clk);
      chk("mid_reached", rise_cnt, 11);
      reset_n = 1'b0;
      #1;
      chk("mid_cs", cs, 1);
      chk("mid_sck", sck, 0);
      chk("mid_busy", busy, 0);
      repeat (4) @(negedge clk);
      chk("mid_no_done", dn_cnt, 0);
      reset_n = 1'b1;
      @(negedge clk);
      clear();
      go(1'b0, 7'h33, 8'd0);
      wait_done(200, -1);
      chk("post_rises", rise_cnt, 8);
      chk("post_mosi", cap[7:0], 8'h33);
      chk("post_done", dn_cnt, 1);

      // CLK_DIV=1 phase timing.
      clear();
      rw1 = 1'b1; addr1 = 7'h2A; len1 = 8'd1; txData1 = 8'hC3; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      for (int n = 0; n < 100 && done1 !== 1'b1; n++) @(negedge clk);
      chk("d1_done", done1, 1);
      chk("d1_rises", rise1, 16);
      chk("d1_mosi", cap1[15:0], 16'hAAC3);
      chk("d1_phase", bad1, 0);
      chk("d1_mosi_stable", chg1, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
